if_fetch_unit: RTL

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues word fetches to instruction memory over a request/ready handshake of variable latency, and drives the IF/ID pipeline register. It presents one fetched instruction with its PC+4 per delivery, NOP bubbles while memory is busy, and a stable hold while the hazard unit freezes the front end. Taken branches from EXE redirect the PC, flush IF/ID, and discard any in-flight fetch.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready
// handshake and drives the IF/ID register with delivered words or bubbles.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        flush_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic [31:0]  pc_next;

  assign pc_next         = pc_q + PC_STEP;
  assign imem_req        = (state_q != S_WAIT);
  assign imem_addr       = req_addr_q;
  assign flush_out       = branch_taken;
  assign pc_out          = pc_out_q;
  assign instruction_out = inst_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_inst_q <= NOP_INST;
      pc_out_q   <= 32'h0;
      inst_out_q <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_inst_q <= buf_inst_d;
      pc_out_q   <= pc_out_d;
      inst_out_q <= inst_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_inst_d = buf_inst_q;
    pc_out_d   = pc_out_q;
    inst_out_d = inst_out_q;

    if (branch_taken) begin
      // An unanswered request must still be drained; its address stays put.
      pc_d       = branch_addr;
      pc_out_d   = 32'h0;
      inst_out_d = NOP_INST;
      buf_inst_d = NOP_INST;
      if (imem_req && !imem_ready) begin
        state_d = S_DRAIN;
      end else begin
        state_d    = S_FETCH;
        req_addr_d = branch_addr;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            if (!freeze) begin
              inst_out_d = imem_rdata;
              pc_out_d   = pc_next;
              pc_d       = pc_next;
              req_addr_d = pc_next;
            end else begin
              buf_inst_d = imem_rdata;
              state_d    = S_WAIT;
            end
          end else if (!freeze) begin
            inst_out_d = NOP_INST;
            pc_out_d   = 32'h0;
          end
        end
        S_WAIT: begin
          if (!freeze) begin
            inst_out_d = buf_inst_q;
            pc_out_d   = pc_next;
            pc_d       = pc_next;
            req_addr_d = pc_next;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          inst_out_d = NOP_INST;
          pc_out_d   = 32'h0;
          if (imem_ready) begin
            req_addr_d = pc_q;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
